// File: rtl/counter_seq_pkg.sv
// Shared encodings for the counter sequencer: command ops, FSM states and default width.
// Optional feature macro used by this block: COUNTER_SEQ_SATURATE_EN.
package counter_seq_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_LOAD = 2'd1,
    OP_UP   = 2'd2,
    OP_DOWN = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_STEP = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic is_step_op(input op_t op);
    return (op == OP_UP) || (op == OP_DOWN);
  endfunction

endpackage

// File: rtl/counter_seq_core.sv
// Counter datapath: loadable up/down register with wrap (default) or saturation
// (COUNTER_SEQ_SATURATE_EN) and a sticky limit flag cleared at each command accept.
module counter_seq_core
  import counter_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             step_en,
  input  logic             step_up,
  input  logic             clr_limit,
  output logic [WIDTH-1:0] count,
  output logic             limit_hit
);

  localparam logic [WIDTH-1:0] MAX_VAL = '1;

  logic             at_edge;
  logic [WIDTH-1:0] stepped;

  always_comb begin
    at_edge = step_up ? (count == MAX_VAL) : (count == '0);
    stepped = step_up ? count + 1'b1 : count - 1'b1;
`ifdef COUNTER_SEQ_SATURATE_EN
    // Clamp at the rails; the step still consumes a slot of the command.
    if (at_edge) stepped = count;
`else
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count     <= '0;
      limit_hit <= 1'b0;
    end else begin
      if (load) begin
        count <= load_val;
      end else if (step_en) begin
        count <= stepped;
      end
      if (clr_limit) begin
        limit_hit <= 1'b0;
      end else if (step_en && at_edge) begin
        limit_hit <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/counter_sequencer.sv
// Command-driven sequencer for an up/down counter: FSM, handshake and step countdown.
// Build with COUNTER_SEQ_SATURATE_EN to clamp at the rails instead of wrapping.
module counter_sequencer
  import counter_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmdValid,
  output logic             cmdReady,
  input  logic [1:0]       cmdOp,
  input  logic [WIDTH-1:0] cmdArg,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             limitHit,
  output state_t           dbg_state
);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] remaining;
  logic             dir_up;
  logic             accept;
  op_t              op;

  // Handshake: a command transfers on a rising edge where cmdValid && cmdReady.
  // cmdReady is registered and high only in IDLE; an unaccepted command must be
  // held by the caller, and cmdOp/cmdArg are sampled only on the accept edge.
  assign op     = op_t'(cmdOp);
  assign accept = cmdValid && cmdReady;

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          state_next = (is_step_op(op) && (cmdArg != '0)) ? ST_STEP : ST_DONE;
        end
      end
      ST_STEP: begin
        busy = 1'b1;
        if (remaining == WIDTH'(1)) state_next = ST_DONE;
      end
      ST_DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      cmdReady  <= 1'b0;
      remaining <= '0;
      dir_up    <= 1'b0;
    end else begin
      state    <= state_next;
      cmdReady <= (state_next == ST_IDLE);
      if (accept && is_step_op(op)) begin
        remaining <= cmdArg;
        dir_up    <= (op == OP_UP);
      end else if (state == ST_STEP) begin
        remaining <= remaining - 1'b1;
      end
    end
  end

  assign dbg_state = state;

  counter_seq_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk      (clk),
    .reset    (reset),
    .load     (accept && (op == OP_LOAD)),
    .load_val (cmdArg),
    .step_en  (state == ST_STEP),
    .step_up  (dir_up),
    .clr_limit(accept),
    .count    (count),
    .limit_hit(limitHit)
  );

endmodule
